// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser and per-channel debounce FSM with registered edge pulses.
// Define SWITCH_DEBOUNCE_TOGGLE_EN to add sw_toggle, which flips on every debounced rising edge.
module switch_debouncer #(
  parameter int NUM_SW = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_clean,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  ,
  output logic [NUM_SW-1:0] sw_toggle
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  typedef enum logic {STABLE, PENDING} state_t;
  logic [NUM_SW-1:0] s1, s2, mis, upd;
  state_t st [NUM_SW];
  state_t st_n [NUM_SW];
  logic [CW-1:0] cnt [NUM_SW];
  logic [CW-1:0] cnt_n [NUM_SW];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      sw_clean <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        st[i] <= STABLE;
        cnt[i] <= '0;
      end
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
      sw_clean <= sw_clean ^ upd;
      sw_rise <= upd & s2;
      sw_fall <= upd & ~s2;
      for (int i = 0; i < NUM_SW; i++) begin
        st[i] <= st_n[i];
        cnt[i] <= cnt_n[i];
      end
    end
  end
  // A mismatch in STABLE enters PENDING with cnt = 1 (cnt is 0 there), so CMAX = 1 accepts one cycle later.
  always_comb begin
    mis = s2 ^ sw_clean;
    upd = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      upd[i] = mis[i] && st[i] == PENDING && cnt[i] == CMAX;
      st_n[i] = (mis[i] && !upd[i]) ? PENDING : STABLE;
      cnt_n[i] = (mis[i] && !upd[i]) ? cnt[i] + 1'b1 : '0;
    end
  end
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  always_ff @(posedge clk)
    sw_toggle <= !rst_n ? '0 : sw_toggle ^ sw_rise;
`endif
endmodule
